// File: rtl/dmem_dump_pkg.sv
// dmem_dump_pkg: shared types and constants for the data-memory dump engine
package dmem_dump_pkg;
  localparam int WORD_W = 32;
  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, SEND, FIN} state_e;
endpackage

// File: rtl/dmem_dump_engine.sv
// dmem_dump_engine: walks data memory 0..DEPTH-1, streams each word over valid/ready
// and accumulates a wrapping 32-bit checksum of the handshaken words.
module dmem_dump_engine
  import dmem_dump_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [WORD_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic [WORD_W-1:0] checksum
);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  state_e              state_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [WORD_W-1:0]   checksum_q;
  logic [WORD_W-1:0]   out_data_q;
  logic [ADDR_W-1:0]   out_index_q;
  logic                out_valid_q;
  logic                out_last_q;
  logic                done_q;
  logic                busy_q;
  // The read strobe is decoded straight from state so the read lands in CAPTURE.
  always_comb begin
    mem_rd_en   = state_q == ISSUE;
    mem_rd_addr = mem_rd_en ? idx_q : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      checksum_q  <= '0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          idx_q      <= '0;
          checksum_q <= '0;
          busy_q     <= 1'b1;
          state_q    <= ISSUE;
        end
        ISSUE: state_q <= CAPTURE;
        CAPTURE: begin
          out_data_q  <= mem_rd_data;
          out_index_q <= idx_q;
          out_last_q  <= idx_q == LAST_IDX;
          out_valid_q <= 1'b1;
          state_q     <= SEND;
        end
        SEND: if (out_ready) begin
          out_valid_q <= 1'b0;
          checksum_q  <= checksum_q + out_data_q;
          if (idx_q == LAST_IDX) begin
            done_q  <= 1'b1;
            state_q <= FIN;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= ISSUE;
          end
        end
        FIN: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;
  assign checksum  = checksum_q;
endmodule

// File: tb/tb_dmem_dump_engine.sv
// tb_dmem_dump_engine: table-driven dump runs with a word scoreboard, plus a DEPTH=4 back-to-back sequence
module tb_dmem_dump_engine;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic start64 = 1'b0, ready64 = 1'b0, busy64, done64, rd_en64, valid64, last64;
  logic [5:0] addr64, idx64;
  logic [31:0] rdata64, data64, sum64;
  logic start4 = 1'b0, ready4 = 1'b0, busy4, done4, rd_en4, valid4, last4;
  logic [1:0] addr4, idx4;
  logic [31:0] rdata4, data4, sum4;
  logic [31:0] mem64 [64];
  logic [31:0] mem4 [4];
  always_ff @(posedge clk) begin
    if (rd_en64) rdata64 <= mem64[addr64];
    if (rd_en4) rdata4 <= mem4[addr4];
  end
  dmem_dump_engine #(.DEPTH(64), .ADDR_W(6)) dut64 (
    .clk(clk), .rst(rst), .start(start64), .busy(busy64), .done(done64),
    .mem_rd_en(rd_en64), .mem_rd_addr(addr64), .mem_rd_data(rdata64),
    .out_valid(valid64), .out_ready(ready64), .out_data(data64), .out_index(idx64),
    .out_last(last64), .checksum(sum64));
  dmem_dump_engine #(.DEPTH(4), .ADDR_W(2)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .busy(busy4), .done(done4),
    .mem_rd_en(rd_en4), .mem_rd_addr(addr4), .mem_rd_data(rdata4),
    .out_valid(valid4), .out_ready(ready4), .out_data(data4), .out_index(idx4),
    .out_last(last4), .checksum(sum4));
  int passed = 0, total = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  typedef struct {logic [5:0] idx; logic [31:0] data; logic last;} word_t;
  word_t exp_q[$];
  typedef struct {bit ones; bit stall; bit extra; int rst_hs; logic [31:0] sum; int done_cyc;} run_t;
  run_t runs[6];
  task automatic run64(input int r);
    run_t t = runs[r];
    int rd_cnt = 0, done_cnt = 0, done_cyc = -1, stall_left = 0, hs = 0, stalled_idx = -1;
    bit prev_stall = 0;
    logic [31:0] hd = '0;
    logic [5:0] hi = '0;
    word_t w;
    for (int i = 0; i < 64; i++) begin
      mem64[i] = t.ones ? 32'hFFFF_FFFF : i * 32'h0101_0101;
      exp_q.push_back('{idx: 6'(i), data: mem64[i], last: i == 63});
    end
    @(negedge clk);
    start64 = 1'b1;
    ready64 = 1'b1;
    for (int cyc = 1; cyc < 3000; cyc++) begin
      @(negedge clk);
      start64 = t.extra && (cyc == 10 || cyc == 50);
      if (prev_stall) begin
        chk($sformatf("run%0d stall_valid", r), valid64, 1);
        chk($sformatf("run%0d stall_data", r), data64, hd);
        chk($sformatf("run%0d stall_index", r), idx64, hi);
      end
      if (rd_en64) begin
        rd_cnt++;
        if (exp_q.size() > 0) chk($sformatf("run%0d rd_addr", r), addr64, exp_q[0].idx);
      end
      if (t.stall && valid64 && idx64[0] && int'(idx64) != stalled_idx) begin
        stall_left = 5;
        stalled_idx = int'(idx64);
      end
      ready64 = stall_left == 0;
      if (stall_left > 0) stall_left--;
      prev_stall = valid64 && !ready64;
      hd = data64;
      hi = idx64;
      if (valid64 && ready64) begin
        if (t.rst_hs == int'(idx64)) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          chk($sformatf("run%0d rst_valid", r), valid64, 0);
          chk($sformatf("run%0d rst_busy", r), busy64, 0);
          chk($sformatf("run%0d rst_checksum", r), sum64, 0);
          chk($sformatf("run%0d rst_done", r), done64, 0);
          repeat (5) begin
            @(negedge clk);
            chk($sformatf("run%0d post_rst_done", r), done64, 0);
            chk($sformatf("run%0d post_rst_valid", r), valid64, 0);
          end
          exp_q.delete();
          return;
        end
        if (exp_q.size() == 0) chk($sformatf("run%0d extra_word", r), 1, 0);
        else begin
          w = exp_q.pop_front();
          chk($sformatf("run%0d data", r), data64, w.data);
          chk($sformatf("run%0d index", r), idx64, w.idx);
          chk($sformatf("run%0d last", r), last64, w.last);
          if (!t.stall) chk($sformatf("run%0d hs_cycle", r), cyc, 3 + 3 * hs);
          hs++;
        end
      end
      if (done64) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        chk($sformatf("run%0d done_checksum", r), sum64, t.sum);
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
    end
    chk($sformatf("run%0d words_left", r), exp_q.size(), 0);
    chk($sformatf("run%0d done_count", r), done_cnt, 1);
    chk($sformatf("run%0d rd_count", r), rd_cnt, 64);
    if (t.done_cyc > 0) chk($sformatf("run%0d done_cycle", r), done_cyc, t.done_cyc);
    chk($sformatf("run%0d busy_after", r), busy64, 0);
    chk($sformatf("run%0d checksum_hold", r), sum64, t.sum);
    exp_q.delete();
  endtask
  initial begin
    int hs, dones, k;
    runs[0] = '{ones: 0, stall: 0, extra: 0, rst_hs: -1, sum: 32'hE7E7_E7E0, done_cyc: 193};
    runs[1] = '{ones: 0, stall: 1, extra: 0, rst_hs: -1, sum: 32'hE7E7_E7E0, done_cyc: 0};
    runs[2] = '{ones: 0, stall: 0, extra: 1, rst_hs: -1, sum: 32'hE7E7_E7E0, done_cyc: 193};
    runs[3] = '{ones: 0, stall: 0, extra: 0, rst_hs: 20, sum: 32'h0, done_cyc: 0};
    runs[4] = '{ones: 0, stall: 0, extra: 0, rst_hs: -1, sum: 32'hE7E7_E7E0, done_cyc: 193};
    runs[5] = '{ones: 1, stall: 0, extra: 0, rst_hs: -1, sum: 32'hFFFF_FFC0, done_cyc: 193};
    repeat (2) @(negedge clk);
    chk("reset busy", busy64, 0);
    chk("reset done", done64, 0);
    chk("reset rd_en", rd_en64, 0);
    chk("reset rd_addr", addr64, 0);
    chk("reset valid", valid64, 0);
    chk("reset last", last64, 0);
    chk("reset data", data64, 0);
    chk("reset index", idx64, 0);
    chk("reset checksum", sum64, 0);
    rst = 1'b0;
    for (int r = 0; r < 6; r++) run64(r);
    mem4[0] = 32'd1; mem4[1] = 32'd2; mem4[2] = 32'd3; mem4[3] = 32'd4;
    @(negedge clk);
    start4 = 1'b1;
    ready4 = 1'b1;
    hs = 0;
    dones = 0;
    for (int cyc = 1; cyc <= 32; cyc++) begin
      @(negedge clk);
      start4 = cyc == 13 || cyc == 14;
      if (cyc == 14) chk("d4 busy_after_fin_start", busy4, 0);
      if (cyc == 15) begin
        chk("d4 restart_busy", busy4, 1);
        chk("d4 restart_rd_en", rd_en4, 1);
        chk("d4 restart_addr", addr4, 0);
      end
      if (valid4 && ready4) begin
        k = hs % 4;
        chk("d4 data", data4, mem4[k]);
        chk("d4 index", idx4, k);
        chk("d4 last", last4, k == 3);
        chk("d4 hs_cycle", cyc, hs < 4 ? 3 + 3 * hs : 17 + 3 * (hs - 4));
        hs++;
      end
      if (done4) begin
        dones++;
        chk("d4 done_cycle", cyc, dones == 1 ? 13 : 27);
        chk("d4 checksum", sum4, 10);
      end
    end
    chk("d4 handshakes", hs, 8);
    chk("d4 done_count", dones, 2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
